// File: rtl/sys_pkg.sv
// ---------------------------------------------------------------------------
// sys_pkg
// Shared definitions for the syscall controller (sys_ctrl_unit / sys_fifo).
//   SYS_DISPLAY / SYS_EXIT / SYS_STATUS : syscall codes carried on rs
//   sys_state_e                         : controller state (RUN, DRAIN, HALT)
// ---------------------------------------------------------------------------
package sys_pkg;

    localparam int unsigned SYS_DISPLAY = 1;
    localparam int unsigned SYS_EXIT    = 2;
    localparam int unsigned SYS_STATUS  = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } sys_state_e;

endpackage : sys_pkg

// File: rtl/sys_fifo.sv
// ---------------------------------------------------------------------------
// sys_fifo
// Display-value buffer for the syscall controller. Circular buffer with
// power-of-two depth; pointers wrap naturally on their PTR_W bits.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (control only)
//   push_i, data_i : write request and value (ignored when full)
//   pop_i          : read request (ignored when empty)
//   full_o/empty_o : occupancy flags, derived from the registered count
//   count_o        : number of stored entries (PTR_W+1 bits)
//   head_o         : oldest entry, forced to zero while empty
// ---------------------------------------------------------------------------
module sys_fifo #(
    parameter  int DATA_W     = 32,
    parameter  int FIFO_DEPTH = 8,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [DATA_W-1:0] head_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    // Zero while empty so the console data reads 0 out of reset.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Overflow/underflow protection: requests against full/empty are dropped.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is data only; a flushed FIFO never exposes stale entries
    // because head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : sys_fifo

// File: rtl/sys_ctrl_unit.sv
// ---------------------------------------------------------------------------
// sys_ctrl_unit
// Syscall controller: buffers DISPLAY values and drains them to a console
// valid/ready port, sequences EXIT as drain-then-halt, answers STATUS with
// the FIFO count, and flags unknown syscall codes.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   req_valid, instr_id     : processor request and decoded instruction ID
//   rs, rt                  : syscall code, display value
//   req_ready               : combinational accept (stall when low)
//   rd, rd_valid            : STATUS result, one-cycle qualifier
//   con_valid, con_data     : console data (FIFO head), con_ready accepts
//   halted                  : program exited and FIFO drained
//   err_bad_code            : sticky unknown-code flag
// Optional build macro SYS_TRACE_EN: simulation-only console trace and
// $finish one cycle after halted rises.
// ---------------------------------------------------------------------------
module sys_ctrl_unit
    import sys_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_SYSCALL = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       instr_id,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              req_ready,
    output logic [DATA_W-1:0] rd,
    output logic              rd_valid,
    output logic              con_valid,
    output logic [DATA_W-1:0] con_data,
    input  logic              con_ready,
    output logic              halted,
    output logic              err_bad_code
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    sys_state_e        state_q;
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid_q;
    logic              halted_q;
    logic              err_q;

    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic is_sys, code_disp, code_exit, code_status, code_bad;
    logic sys_acc, push, pop;

    // Request decode
    assign is_sys      = (instr_id == 32'(ID_SYSCALL));
    assign code_disp   = (rs == DATA_W'(SYS_DISPLAY));
    assign code_exit   = (rs == DATA_W'(SYS_EXIT));
    assign code_status = (rs == DATA_W'(SYS_STATUS));
    assign code_bad    = !(code_disp || code_exit || code_status);

    // Full is judged on the registered count, so a pop in the same cycle
    // does not release a stalled DISPLAY.
    assign req_ready = (state_q == RUN) && !(is_sys && code_disp && fifo_full);
    assign sys_acc   = req_valid && req_ready && is_sys;
    assign push      = sys_acc && code_disp;
    assign pop       = con_valid && con_ready;

    sys_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (rt),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign con_valid    = !fifo_empty;
    assign con_data     = fifo_head;
    assign rd           = rd_q;
    assign rd_valid     = rd_valid_q;
    assign halted       = halted_q;
    assign err_bad_code = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            // STATUS reports the count before this edge's push/pop.
            if (sys_acc && code_status) begin
                rd_q       <= DATA_W'(fifo_count);
                rd_valid_q <= 1'b1;
            end
            if (sys_acc && code_bad) err_q <= 1'b1;

            case (state_q)
                RUN: begin
                    if (sys_acc && code_exit) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef SYS_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (con_valid && con_ready) $display("[sys_ctrl_unit] console: %0h", con_data);
            if (halted_q) $finish;
        end
    end
`endif

endmodule : sys_ctrl_unit
